// File: rtl/instr_realigner.sv
// Fetch-word to instruction realigner: splits 32-bit fetch words into 16/32-bit
// RISC-V instructions with PCs. Halfwords carried over between words sit in a one-entry buffer.
module instr_realigner #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  input  logic                  fetch_valid_i,
  output logic                  fetch_ready_o,
  input  logic [31:0]           fetch_data_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_instr_o,
  output logic                  out_compressed_o,
  output logic [ADDR_WIDTH-1:0] out_pc_o
);

  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic                  out_comp_q, out_comp_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                  hb_valid_q, hb_valid_d;
  logic [15:0]           hb_data_q, hb_data_d;
  logic [ADDR_WIDTH-1:0] hb_pc_q, hb_pc_d;
  logic                  skip_lo_q, skip_lo_d;

  logic                  slot_free;
  logic                  hb_comp;
  logic                  fetch_fire;
  logic                  lo_comp;
  logic [ADDR_WIDTH-1:0] hi_pc;

  assign slot_free     = !out_valid_q | out_ready_i;
  assign hb_comp       = (hb_data_q[1:0] != 2'b11);
  // A buffered compressed halfword must drain before a new word can be taken.
  assign fetch_ready_o = slot_free & !flush_i & !(hb_valid_q & hb_comp);
  assign fetch_fire    = fetch_valid_i & fetch_ready_o;
  assign lo_comp       = (fetch_data_i[1:0] != 2'b11);
  assign hi_pc         = fetch_addr_i + ADDR_WIDTH'(2);

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_comp_d  = out_comp_q;
    out_pc_d    = out_pc_q;
    hb_valid_d  = hb_valid_q;
    hb_data_d   = hb_data_q;
    hb_pc_d     = hb_pc_q;
    skip_lo_d   = skip_lo_q;
    if (flush_i) begin
      // Flush wins even under back-pressure: the held output is discarded.
      out_valid_d = 1'b0;
      hb_valid_d  = 1'b0;
      skip_lo_d   = flush_pc_i[1];
    end else if (slot_free) begin
      out_valid_d = 1'b0;
      if (hb_valid_q && hb_comp) begin
        out_valid_d = 1'b1;
        out_instr_d = {16'h0, hb_data_q};
        out_comp_d  = 1'b1;
        out_pc_d    = hb_pc_q;
        hb_valid_d  = 1'b0;
      end else if (hb_valid_q && fetch_fire) begin
        out_valid_d = 1'b1;
        out_instr_d = {fetch_data_i[15:0], hb_data_q};
        out_comp_d  = 1'b0;
        out_pc_d    = hb_pc_q;
        hb_data_d   = fetch_data_i[31:16];
        hb_pc_d     = hi_pc;
        hb_valid_d  = 1'b1;
      end else if (!hb_valid_q && fetch_fire) begin
        if (skip_lo_q) begin
          // Redirect landed on the upper halfword; the lower one is dropped.
          hb_data_d  = fetch_data_i[31:16];
          hb_pc_d    = hi_pc;
          hb_valid_d = 1'b1;
          skip_lo_d  = 1'b0;
        end else if (lo_comp) begin
          out_valid_d = 1'b1;
          out_instr_d = {16'h0, fetch_data_i[15:0]};
          out_comp_d  = 1'b1;
          out_pc_d    = fetch_addr_i;
          hb_data_d   = fetch_data_i[31:16];
          hb_pc_d     = hi_pc;
          hb_valid_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_instr_d = fetch_data_i;
          out_comp_d  = 1'b0;
          out_pc_d    = fetch_addr_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_comp_q  <= 1'b0;
      out_pc_q    <= '0;
      hb_valid_q  <= 1'b0;
      hb_data_q   <= '0;
      hb_pc_q     <= '0;
      skip_lo_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_comp_q  <= out_comp_d;
      out_pc_q    <= out_pc_d;
      hb_valid_q  <= hb_valid_d;
      hb_data_q   <= hb_data_d;
      hb_pc_q     <= hb_pc_d;
      skip_lo_q   <= skip_lo_d;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_instr_o      = out_instr_q;
  assign out_compressed_o = out_comp_q;
  assign out_pc_o         = out_pc_q;

endmodule

// File: tb/tb_instr_realigner.sv
// Scoreboard bench for instr_realigner: directed fetch words, expected
// instructions queued at issue time and checked by an independent monitor.
module tb_instr_realigner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic [31:0] fetch_addr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic        out_compressed_o;
  logic [31:0] out_pc_o;

  instr_realigner #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_data_i(fetch_data_i), .fetch_addr_i(fetch_addr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o), .out_compressed_o(out_compressed_o),
    .out_pc_o(out_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        comp;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic expect_out(input logic [31:0] instr, input logic comp, input logic [31:0] pc);
    exp_t e;
    e.instr = instr; e.comp = comp; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted output transfer must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got instr=%h comp=%0d pc=%h, none expected",
                 out_instr_o, out_compressed_o, out_pc_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_xfer", {15'h0, out_instr_o, out_compressed_o, out_pc_o},
            {15'h0, e.instr, e.comp, e.pc});
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input logic [31:0] a);
    int n;
    n = 0;
    fetch_valid_i = 1'b1; fetch_data_i = d; fetch_addr_i = a;
    @(negedge clk);
    while (!fetch_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!fetch_ready_o) begin
      total++; bad++;
      $display("FAIL fetch_timeout: word %h never accepted", d);
    end
    @(posedge clk); #1;
    fetch_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    fetch_valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
    fetch_valid_i = 1'b0; fetch_data_i = '0; fetch_addr_i = '0;
    out_ready_i = 1'b1;
    #2;
    chk("rst_outputs", {15'h0, out_instr_o, out_compressed_o, out_pc_o}, 80'h0);
    chk("rst_valid", {79'h0, out_valid_o}, 80'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("rst_fetch_ready", {79'h0, fetch_ready_o}, 80'h1);

    // Aligned 32-bit instruction
    expect_out(32'h00500093, 1'b0, 32'h0);
    push_word(32'h00500093, 32'h0);
    chk("aligned_valid", {79'h0, out_valid_o}, 80'h1);
    chk("aligned_no_hb", {79'h0, fetch_ready_o}, 80'h1);
    idle(3);

    // Two compressed instructions in one word
    expect_out(32'h00004585, 1'b1, 32'h0);
    expect_out(32'h00004505, 1'b1, 32'h2);
    push_word(32'h45054585, 32'h0);
    chk("two_c_ready_low", {79'h0, fetch_ready_o}, 80'h0);
    idle(3);

    // 32-bit instruction straddling two words
    expect_out(32'h00004585, 1'b1, 32'h0);
    expect_out(32'h00500093, 1'b0, 32'h2);
    expect_out(32'h00004585, 1'b1, 32'h6);
    push_word(32'h00934585, 32'h0);
    push_word(32'h45850050, 32'h4);
    idle(4);

    // Back-pressure with a further word waiting
    out_ready_i = 1'b0;
    expect_out(32'h00004585, 1'b1, 32'h8);
    expect_out(32'h00004505, 1'b1, 32'ha);
    expect_out(32'h00500093, 1'b0, 32'hc);
    push_word(32'h45054585, 32'h8);
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00500093; fetch_addr_i = 32'hc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {79'h0, out_valid_o}, 80'h1);
      chk("bp_hold", {15'h0, out_instr_o, out_compressed_o, out_pc_o},
          {15'h0, 32'h00004585, 1'b1, 32'h8});
      chk("bp_fetch_ready", {79'h0, fetch_ready_o}, 80'h0);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    push_word(32'h00500093, 32'hc);
    idle(4);

    // Flush to a halfword target while output and buffer are both occupied
    out_ready_i = 1'b0;
    push_word(32'h45054585, 32'h20);
    flush_i = 1'b1; flush_pc_i = 32'h102;
    @(negedge clk);
    chk("flush_fetch_ready", {79'h0, fetch_ready_o}, 80'h0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_out_cleared", {79'h0, out_valid_o}, 80'h0);
    out_ready_i = 1'b1;
    expect_out(32'h00000001, 1'b1, 32'h102);
    push_word(32'h00014585, 32'h100);
    chk("skip_cycle_no_out", {79'h0, out_valid_o}, 80'h0);
    @(posedge clk); #1;
    chk("after_skip_valid", {79'h0, out_valid_o}, 80'h1);
    idle(3);

    // Reset in the middle of a straddle
    expect_out(32'h00004585, 1'b1, 32'h40);
    push_word(32'h00934585, 32'h40);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {15'h0, out_instr_o, out_compressed_o, out_pc_o}, 80'h0);
    chk("midrst_valid", {79'h0, out_valid_o}, 80'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    expect_out(32'h00500093, 1'b0, 32'h80);
    push_word(32'h00500093, 32'h80);
    chk("postrst_ready", {79'h0, fetch_ready_o}, 80'h1);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    idle(3);
    chk("queue_drained", {48'h0, 32'(exp_q.size())}, 80'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_realigner.md
Name: instr_realigner

Overview:
- Sits between the instruction-memory fetch port and the RVC decompressor.
- Accepts word-aligned 32-bit fetch words and extracts one 16-bit (compressed) or 32-bit instruction per output transfer, with the instruction's PC.
- Handles 32-bit instructions straddling two fetch words, and redirects to halfword-aligned targets.
- Output is registered; the decompressor consumes out_instr_o[15:0] when out_compressed_o=1.

Parameters:
- ADDR_WIDTH, 32, width of fetch address and PC.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- flush_i  input  1  redirect; drop all buffered state
- flush_pc_i  input  ADDR_WIDTH  redirect target, bit0=0, bit1 may be 1
- fetch_valid_i  input  1  fetch word valid
- fetch_ready_o  output  1  word accepted when valid&ready
- fetch_data_i  input  32  fetch word, little-endian halfwords
- fetch_addr_i  input  ADDR_WIDTH  word address, bits[1:0]=0
- out_valid_o  output  1  instruction valid
- out_ready_i  input  1  downstream accepts
- out_instr_o  output  32  instruction; compressed in [15:0], [31:16]=0
- out_compressed_o  output  1  1 when instr[1:0]!=2'b11
- out_pc_o  output  ADDR_WIDTH  PC of out_instr_o

Behaviour:
- Reset (async, reset_n=0):
  - out_valid_o=0, out_instr_o=0, out_compressed_o=0, out_pc_o=0.
  - Internal state: hb_valid=0, hb_data=0, hb_pc=0, skip_lo=0.
- Internal halfword buffer:
  - hb_data is 16 bits, with hb_pc and hb_valid.
  - hb_comp = (hb_data[1:0]!=2'b11).
- Slot free:
  - slot_free = !out_valid_o | out_ready_i.
  - Output registers update only when slot_free.
  - out_* hold stable while out_valid_o=1 and out_ready_i=0.
- fetch_ready_o is combinational: slot_free & !flush_i & !(hb_valid & hb_comp).
- Priority per cycle, evaluated when slot_free (a missing emit clears out_valid_o):
  1. flush_i:
     - Next out_valid_o=0, hb_valid=0, skip_lo=flush_pc_i[1].
     - No fetch consumed.
     - Flush applies even if !slot_free (out_valid_o cleared).
  2. hb_valid & hb_comp:
     - Emit {16'h0,hb_data}, compressed=1, pc=hb_pc.
     - hb_valid=0. No fetch consumed.
  3. hb_valid & !hb_comp & fetch accepted:
     - Emit {fetch_data_i[15:0],hb_data}, compressed=0, pc=hb_pc.
     - hb_data=fetch_data_i[31:16], hb_pc=fetch_addr_i+2, hb_valid=1.
  4. !hb_valid & skip_lo & fetch accepted:
     - No emit.
     - hb_data=fetch_data_i[31:16], hb_pc=fetch_addr_i+2, hb_valid=1, skip_lo=0.
  5. !hb_valid & fetch accepted & fetch_data_i[1:0]!=2'b11:
     - Emit {16'h0,fetch_data_i[15:0]}, compressed=1, pc=fetch_addr_i.
     - hb_data=fetch_data_i[31:16], hb_pc=fetch_addr_i+2, hb_valid=1.
  6. !hb_valid & fetch accepted & fetch_data_i[1:0]==2'b11:
     - Emit fetch_data_i, compressed=0, pc=fetch_addr_i. hb_valid stays 0.
  7. Otherwise: out_valid_o=0.
- Latency: one cycle from fetch acceptance to out_valid_o.
- Throughput: one instruction/cycle sustained with out_ready_i=1. A 32-bit instruction straddling words waits for the next fetch word, so it issues in the cycle that word is accepted.
- After a flush, upstream restarts fetch at {flush_pc_i[31:2],2'b00}. Words arriving in the flush cycle are not accepted (fetch_ready_o=0).
- PC arithmetic is modulo 2^ADDR_WIDTH.
- Reset mid-operation discards everything immediately.

Test Plan:
- Single aligned 32-bit word 0x00500093 at addr 0x0 -> one cycle later out_valid_o=1, instr 0x00500093, compressed=0, pc 0x0; hb_valid stays 0.
- Word 0x4505_4585 at addr 0x0 (two compressed) -> outputs 0x00004585 pc 0x0 then 0x00004505 pc 0x2 on consecutive cycles. fetch_ready_o=0 during the second cycle.
- Straddle: word 0x0093_4585 @0x0, then word 0x4585_0050 @0x4 -> 0x00004585 pc 0x0, then 0x00500093 pc 0x2, then 0x00004585 pc 0x6.
- Back-pressure: hold out_ready_i=0 for 3 cycles with output valid -> out_* unchanged, fetch_ready_o=0, no word lost; resumes correctly on release.
- Flush to 0x102 while hb_valid=1 and out_valid_o=1 -> next cycle out_valid_o=0. Fetch of word @0x100 = 0x0001_xxxx emits 0x00000001 pc 0x102 one cycle after the skip cycle.
- Assert reset_n=0 mid-straddle -> all outputs 0 immediately. After release, the first aligned word is handled with no stale halfword.
